// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request/response port among NUM_REQ L1 requesters.
// One transaction in flight: capture winner, issue to L2, wait for response, strobe it back to the owner.
//
// state    | meaning
// ST_IDLE  | no transaction; grant the round-robin winner and capture its request
// ST_ISSUE | l2_req_valid high with held fields until l2_req_ready
// ST_WAIT  | request accepted by L2, waiting for l2_resp_valid
// ST_RESP  | one-cycle resp_valid strobe to the owner, advance rr pointer
module l2_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ-1:0]           req_rw,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [DATA_W-1:0]            resp_data,
   output logic                         l2_req_valid,
   input  logic                         l2_req_ready,
   output logic [ADDR_W-1:0]            l2_req_addr,
   output logic                         l2_req_rw,
   output logic [DATA_W-1:0]            l2_req_data,
   input  logic                         l2_resp_valid,
   input  logic [DATA_W-1:0]            l2_resp_data,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         protocol_err
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rw_q, rw_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                protocol_err_q, protocol_err_d;

   logic                found;
   logic [ID_W-1:0]     winner;
   logic [ID_W-1:0]     idx_w;
   int                  idx;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_w  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx   = (int'(rr_ptr_q) + off) % NUM_REQ;
         idx_w = ID_W'(idx);
         if (!found && req_valid[idx_w]) begin
            found  = 1'b1;
            winner = idx_w;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_id_d     = grant_id_q;
      addr_d         = addr_q;
      rw_d           = rw_q;
      wdata_d        = wdata_q;
      resp_data_d    = resp_data_q;
      protocol_err_d = protocol_err_q;
      req_ready      = '0;
      resp_valid     = '0;
      l2_req_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               addr_d            = req_addr[winner*ADDR_W +: ADDR_W];
               rw_d              = req_rw[winner];
               wdata_d           = req_data[winner*DATA_W +: DATA_W];
               grant_id_d        = winner;
               state_d           = ST_ISSUE;
            end
            if (l2_resp_valid) begin
               protocol_err_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            l2_req_valid = 1'b1;
            if (l2_req_ready) begin
               // A response arriving with the accept skips WAIT entirely.
               if (l2_resp_valid) begin
                  resp_data_d = l2_resp_data;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (l2_resp_valid) begin
               protocol_err_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (l2_resp_valid) begin
               resp_data_d = l2_resp_data;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid[grant_id_q] = 1'b1;
            rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
            state_d  = ST_IDLE;
            if (l2_resp_valid) begin
               protocol_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         grant_id_q     <= '0;
         addr_q         <= '0;
         rw_q           <= 1'b0;
         wdata_q        <= '0;
         resp_data_q    <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_id_q     <= grant_id_d;
         addr_q         <= addr_d;
         rw_q           <= rw_d;
         wdata_q        <= wdata_d;
         resp_data_q    <= resp_data_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign l2_req_addr  = addr_q;
   assign l2_req_rw    = rw_q;
   assign l2_req_data  = wdata_q;
   assign resp_data    = resp_data_q;
   assign grant_id     = grant_id_q;
   assign busy         = (state_q != ST_IDLE);
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of the arbiter (owner / issued / response-due flags).
module tb_l2_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 1;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr;
   logic [N-1:0]      req_rw;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      resp_valid;
   logic [DW-1:0]     resp_data;
   logic              l2_req_valid;
   logic              l2_req_ready;
   logic [AW-1:0]     l2_req_addr;
   logic              l2_req_rw;
   logic [DW-1:0]     l2_req_data;
   logic              l2_resp_valid;
   logic [DW-1:0]     l2_resp_data;
   logic [IW-1:0]     grant_id;
   logic              busy;
   logic              protocol_err;

   always #5 clk = ~clk;

   l2_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rw(req_rw), .req_data(req_data),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
      .l2_req_addr(l2_req_addr), .l2_req_rw(l2_req_rw), .l2_req_data(l2_req_data),
      .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
      .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
   );

   int total = 0;
   int bad   = 0;

   // requester agents
   bit            p_valid[N];
   logic [AW-1:0] p_addr[N];
   logic          p_rw[N];
   logic [DW-1:0] p_data[N];
   bit            auto_rearm = 0;
   int            arm_pct = 0;

   // reference model: owner=-1 means no transaction in flight
   int            m_owner, m_last, m_rr;
   bit            m_issued, m_resp_due, m_perr;
   logic [AW-1:0] m_addr;
   logic          m_rw;
   logic [DW-1:0] m_wdata, m_rdata;

   // L2 responder knobs
   int  l2_cnt = 0, l2_d_next = 0, hold_rdy = 0;
   int  rdy_pct = 100, fixed_delay = 0, fixed_data = 1;
   bit  force_resp = 0;
   int  obs_grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_winner();
      for (int off = 0; off < N; off++) begin
         int i;
         i = (m_rr + off) % N;
         if (p_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_rr = 0;
      m_issued = 0; m_resp_due = 0; m_perr = 0;
      m_addr = '0; m_rw = 1'b0; m_wdata = '0; m_rdata = '0;
      l2_cnt = 0; hold_rdy = 0; force_resp = 0;
   endtask

   task automatic drive_inputs();
      bit in_issue, in_wait, rdy, rsp;
      for (int i = 0; i < N; i++) begin
         if (auto_rearm && !p_valid[i] && $urandom_range(99) < arm_pct) begin
            p_valid[i] = 1;
            p_addr[i]  = AW'($urandom);
            p_rw[i]    = 1'($urandom);
            p_data[i]  = DW'($urandom);
         end
         req_valid[i]            = p_valid[i];
         req_addr[i*AW +: AW]    = p_addr[i];
         req_rw[i]               = p_rw[i];
         req_data[i*DW +: DW]    = p_data[i];
      end
      in_issue = (m_owner >= 0) && !m_issued && !m_resp_due;
      in_wait  = (m_owner >= 0) && m_issued && !m_resp_due;
      rdy = ($urandom_range(99) < rdy_pct);
      rsp = 0;
      if (in_issue) begin
         if (hold_rdy > 0) begin
            hold_rdy--;
            rdy = 0;
         end
         if (rdy) begin
            l2_d_next = (fixed_delay >= 0) ? fixed_delay : $urandom_range(3);
            if (l2_d_next == 0) rsp = 1;
         end
      end
      if (in_wait) begin
         l2_cnt--;
         if (l2_cnt <= 0) rsp = 1;
      end
      if (force_resp) rsp = 1;
      l2_req_ready  = rdy;
      l2_resp_valid = rsp;
      l2_resp_data  = (fixed_data >= 0) ? DW'(fixed_data) : DW'($urandom);
   endtask

   // Check all outputs mid-cycle, advance the model across the next edge, return at the next negedge.
   task automatic check_and_advance();
      int  w;
      bit  issue, ok_resp;
      #1;
      w = (m_owner < 0) ? pick_winner() : -1;
      issue = (m_owner >= 0) && !m_issued && !m_resp_due;
      chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("resp_valid", 32'(resp_valid), m_resp_due ? (32'd1 << m_owner) : 32'd0);
      chk("l2_req_valid", 32'(l2_req_valid), 32'(issue));
      chk("l2_req_addr", 32'(l2_req_addr), 32'(m_addr));
      chk("l2_req_rw", 32'(l2_req_rw), 32'(m_rw));
      chk("l2_req_data", 32'(l2_req_data), 32'(m_wdata));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("grant_id", 32'(grant_id), 32'(m_last));
      chk("resp_data", 32'(resp_data), 32'(m_rdata));
      chk("protocol_err", 32'(protocol_err), 32'(m_perr));
      for (int i = 0; i < N; i++) if (req_ready[i]) obs_grants.push_back(i);

      ok_resp = 0;
      if (!reset) begin
         if (m_resp_due) begin
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
            m_resp_due = 0;
         end else if (m_owner < 0) begin
            if (w >= 0) begin
               m_owner = w; m_last = w; m_issued = 0;
               m_addr = p_addr[w]; m_rw = p_rw[w]; m_wdata = p_data[w];
               p_valid[w] = 0;
            end
         end else if (!m_issued) begin
            if (l2_req_ready) begin
               m_issued = 1;
               l2_cnt = l2_d_next;
               if (l2_resp_valid) begin
                  m_resp_due = 1; m_rdata = l2_resp_data; ok_resp = 1;
               end
            end
         end else if (l2_resp_valid) begin
            m_resp_due = 1; m_rdata = l2_resp_data; ok_resp = 1;
         end
         if (l2_resp_valid && !ok_resp) m_perr = 1;
      end
      @(negedge clk);
   endtask

   task automatic step();
      drive_inputs();
      check_and_advance();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         p_valid[i] = 0; p_addr[i] = '0; p_rw[i] = 1'b0; p_data[i] = '0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      auto_rearm = 0;
      clear_reqs();
      model_reset();
      steps(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_addr = '0; req_rw = '0; req_data = '0;
      l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;
      clear_reqs();
      model_reset();
      @(negedge clk);
      do_reset();

      // idle after reset
      steps(3);

      // single read from req0, L2 answers two cycles after accept with data 1
      rdy_pct = 100; fixed_delay = 2; fixed_data = 1;
      p_valid[0] = 1; p_addr[0] = 6'h2A; p_rw[0] = 1'b0; p_data[0] = '0;
      steps(7);
      chk("t2_addr", 32'(l2_req_addr), 32'h2A);
      chk("t2_resp_data", 32'(resp_data), 32'd1);

      // all requesters continuously valid, immediate L2
      do_reset();
      fixed_delay = 0; fixed_data = -1;
      auto_rearm = 1; arm_pct = 100;
      obs_grants.delete();
      for (int k = 0; k < 60 && obs_grants.size() < 5; k++) step();
      chk("t3_grant_count", 32'(obs_grants.size() >= 5), 32'd1);
      if (obs_grants.size() >= 5) begin
         for (int g = 0; g < 5; g++) chk("t3_grant_order", 32'(obs_grants[g]), 32'(g % N));
      end
      auto_rearm = 0;

      // write from req2 with L2 stalling five cycles, others requesting meanwhile
      do_reset();
      fixed_delay = 1; fixed_data = 0;
      p_valid[2] = 1; p_addr[2] = 6'h15; p_rw[2] = 1'b1; p_data[2] = 1'b1;
      step();
      hold_rdy = 5;
      p_valid[0] = 1; p_addr[0] = 6'h01;
      p_valid[1] = 1; p_addr[1] = 6'h3C; p_rw[1] = 1'b1;
      steps(10);
      for (int k = 0; k < 40 && (m_owner >= 0 || p_valid[0] || p_valid[1]); k++) step();

      // stray L2 response while idle
      force_resp = 1;
      step();
      force_resp = 0;
      steps(4);
      chk("t5_perr_sticky", 32'(protocol_err), 32'd1);

      // reset during WAIT aborts the transaction
      do_reset();
      fixed_delay = 10;
      p_valid[1] = 1; p_addr[1] = 6'h0F;
      steps(4);
      chk("t6_in_wait", 32'(busy), 32'd1);
      do_reset();
      chk("t6_idle_after_reset", 32'(busy), 32'd0);
      fixed_delay = 0;
      p_valid[3] = 1; p_addr[3] = 6'h33;
      steps(6);
      do_reset();
      p_valid[0] = 1; p_addr[0] = 6'h05;
      p_valid[3] = 1; p_addr[3] = 6'h06;
      steps(10);

      // random traffic
      do_reset();
      auto_rearm = 1; arm_pct = 30; rdy_pct = 60; fixed_delay = -1; fixed_data = -1;
      for (int k = 0; k < 3000; k++) begin
         force_resp = ($urandom_range(199) == 0);
         step();
      end
      force_resp = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
